instr_fetch_unit: RTL and testbench

- Upstream stage of the 16-bit core.
- Owns the program counter, requests instruction words from an instruction memory, and presents each word to the core on `instr_out`.
- Holds `core_run` high until the core signals `core_done`, then advances the PC. The next PC is either sequential or a branch target chosen by `branch_res`.
- Stops fetching on the halt opcode.

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_pc_next.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and instruction-field layout for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  FMT_BRANCH        = 2'b10;
    localparam int          FMT_MSB           = 1;
    localparam int          FMT_LSB           = 0;
    localparam int          OFF_MSB           = 12;
    localparam int          OFF_LSB           = 5;
    localparam int          OFF_W             = OFF_MSB - OFF_LSB + 1;
    localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;

    function automatic logic is_branch(input logic [15:0] w);
        return w[FMT_MSB:FMT_LSB] == FMT_BRANCH;
    endfunction

    function automatic logic [OFF_W-1:0] br_offset(input logic [15:0] w);
        return w[OFF_MSB:OFF_LSB];
    endfunction

endpackage

// File: rtl/ifetch_pc_next.sv
// Combinational next-PC: sequential step or sign-extended branch, both modulo 2^AW.
module ifetch_pc_next
    import ifetch_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0] pc,
    input  logic [15:0]   instr,
    input  logic          branch_res,
    input  logic          take_step,
    output logic [AW-1:0] next_pc
);

    logic [OFF_W-1:0] off;
    logic [AW-1:0]    off_ext;
    logic             unused_instr_bits;

    assign off               = br_offset(instr);
    assign unused_instr_bits = ^{instr[15:13], instr[4:2], off};

    // Narrow PCs just keep the low offset bits; the sum wraps the same way.
    generate
        if (AW > OFF_W) begin : g_sext
            assign off_ext = {{(AW-OFF_W){off[OFF_W-1]}}, off};
        end else begin : g_trunc
            assign off_ext = off[AW-1:0];
        end
    endgenerate

    always_comb begin
        next_pc = pc;
        if (take_step) begin
            if (is_branch(instr) && branch_res) begin
                next_pc = pc + off_ext;
            end else begin
                next_pc = pc + AW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches a word, holds it on the core until done, stops on the halt word.
// Optional IFETCH_PERF_EN adds saturating retired/stall counters.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int          AW        = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rvalid,
    output logic [15:0]   instr_out,
    output logic          core_run,
    input  logic          core_done,
    input  logic          branch_res,
    output logic [AW-1:0] pc,
    output logic          halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   retired_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    fetch_state_t  state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] next_pc_d;
    logic [15:0]   instr_q;
    logic          mem_req_q;
    logic          core_run_q;
    logic          halted_q;
    logic          step;

    assign step = (state_q == S_ISSUE) && core_done;

    ifetch_pc_next #(.AW(AW)) u_pc_next (
        .pc        (pc_q),
        .instr     (instr_q),
        .branch_res(branch_res),
        .take_step (step),
        .next_pc   (next_pc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            core_run_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_rvalid) begin
                        mem_req_q <= 1'b0;
                        // The halt word never reaches the instruction register, so the core never sees it.
                        if (mem_rdata == HALT_WORD) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q    <= S_ISSUE;
                            instr_q    <= mem_rdata;
                            core_run_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (core_done) begin
                        pc_q       <= next_pc_d;
                        state_q    <= S_FETCH;
                        core_run_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        pc_q      <= RESET_PC;
                        state_q   <= S_FETCH;
                        halted_q  <= 1'b0;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    mem_req_q  <= 1'b0;
                    core_run_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pc_q;
    assign instr_out = instr_q;
    assign core_run  = core_run_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (step && (retired_q != 32'hFFFF_FFFF)) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((state_q == S_FETCH) && !mem_rvalid && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed corner sequences and a randomized program run.
module tb_instr_fetch_unit;

    localparam int AW = 8;

    logic          clk, reset, start;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          mem_rvalid;
    logic [15:0]   instr_out;
    logic          core_run, core_done, branch_res;
    logic [AW-1:0] pc;
    logic          halted;
`ifdef IFETCH_PERF_EN
    logic [31:0]   retired_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [256];

    instr_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .instr_out (instr_out),
        .core_run  (core_run),
        .core_done (core_done),
        .branch_res(branch_res),
        .pc        (pc),
        .halted    (halted)
`ifdef IFETCH_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          pre;
        logic [15:0] word;
        logic        br;
        int          exp_next;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; mem_rvalid = 1'b0; core_done = 1'b0; branch_res = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic go_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Memory side: hold rvalid low for 'waits' FETCH cycles, then return 'word'.
    task automatic serve(input int waits, input logic [15:0] word, input bit stray);
        logic [AW-1:0] a;
        bit ok;
        ok = 1'b1;
        a  = mem_addr;
        if (mem_req !== 1'b1) ok = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (stray) begin
                core_done  = 1'($urandom_range(1));
                branch_res = 1'($urandom_range(1));
            end
            tick();
            if (mem_req !== 1'b1 || mem_addr !== a) ok = 1'b0;
        end
        core_done  = 1'b0;
        branch_res = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        chk("fetch_hold", 32'(ok), 32'd1);
        chk("fetch_pc", 32'(pc), 32'(a));
        chk("req_drop", 32'(mem_req), 32'd0);
    endtask

    // Core side: stay busy 'delay' cycles, then pulse done with 'br'.
    task automatic issue(input int delay, input logic br, input bit stray_rv);
        logic [15:0] w;
        bit ok;
        ok = 1'b1;
        w  = instr_out;
        chk("issue_run", 32'(core_run), 32'd1);
        for (int i = 0; i < delay; i++) begin
            if (stray_rv) begin
                mem_rvalid = 1'($urandom_range(1));
                mem_rdata  = 16'($urandom);
            end
            tick();
            mem_rvalid = 1'b0;
            if (core_run !== 1'b1 || instr_out !== w) ok = 1'b0;
        end
        core_done  = 1'b1;
        branch_res = br;
        tick();
        core_done  = 1'b0;
        branch_res = 1'b0;
        chk("issue_hold", 32'(ok), 32'd1);
        chk("run_drop", 32'(core_run), 32'd0);
        chk("refetch_req", 32'(mem_req), 32'd1);
    endtask

    function automatic logic [15:0] nav_word(input int p);
        logic [7:0] b;
        b = 8'(p);
        return {3'b000, b, 3'b000, 2'b10};
    endfunction

    // Reach PC p from reset with one taken branch at address 0.
    task automatic navigate(input int p);
        do_reset();
        go_start();
        serve(1, nav_word(p), 1'b0);
        issue(0, 1'b1, 1'b0);
        chk("nav_addr", 32'(mem_addr), 32'(p));
    endtask

    initial begin
        int mpc;
        int off;
        logic [15:0] w;
        logic        br;

        vecs[0] = '{4,   16'h0FE2, 1'b1, 131};
        vecs[1] = '{4,   16'h1F82, 1'b1, 0};
        vecs[2] = '{4,   16'h0FE2, 1'b0, 5};
        vecs[3] = '{4,   16'h0FE1, 1'b1, 5};
        vecs[4] = '{255, 16'h2408, 1'b0, 0};
        vecs[5] = '{250, 16'h0142, 1'b1, 4};
        vecs[6] = '{3,   16'h1002, 1'b1, 131};
        vecs[7] = '{255, 16'h0FE3, 1'b1, 0};

        reset = 1'b1; start = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        core_done = 1'b0; branch_res = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_run", 32'(core_run), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(instr_out), 32'd0);
        tick();
        reset = 1'b0;

        // Three-word program ending in halt, then restart from HALTED.
        go_start();
        chk("prog_addr0", 32'(mem_addr), 32'd0);
        serve(1, 16'h2408, 1'b0);
        chk("prog_instr0", 32'(instr_out), 32'h2408);
        issue(2, 1'b0, 1'b0);
        chk("prog_addr1", 32'(mem_addr), 32'd1);
        serve(1, 16'h4C05, 1'b0);
        chk("prog_instr1", 32'(instr_out), 32'h4C05);
        issue(0, 1'b1, 1'b0);
        chk("prog_addr2", 32'(mem_addr), 32'd2);
        serve(1, 16'hFFFF, 1'b0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd2);
        chk("halt_run", 32'(core_run), 32'd0);
        tick();
        chk("halt_noreq", 32'(mem_req), 32'd0);
        go_start();
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'd0);

        // Five wait states with stray core_done, then stray rvalid during ISSUE.
        serve(5, 16'h0FE1, 1'b1);
        chk("wait_instr", 32'(instr_out), 32'h0FE1);
        mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rv_instr", 32'(instr_out), 32'h0FE1);
        issue(0, 1'b0, 1'b0);
        chk("wait_next", 32'(mem_addr), 32'd1);

        // Async reset in the middle of ISSUE.
        serve(1, 16'h2408, 1'b0);
        chk("pre_rst_run", 32'(core_run), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_run", 32'(core_run), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_req", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_noreq", 32'(mem_req), 32'd0);
        chk("idle_halted", 32'(halted), 32'd0);

        // start coinciding with a stray rvalid in IDLE.
        start = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        start = 1'b0; mem_rvalid = 1'b0;
        chk("sr_req", 32'(mem_req), 32'd1);
        chk("sr_halted", 32'(halted), 32'd0);
        serve(1, 16'h2408, 1'b0);
        chk("sr_run", 32'(core_run), 32'd1);
        chk("sr_instr", 32'(instr_out), 32'h2408);

        for (int i = 0; i < 8; i++) begin
            navigate(vecs[i].pre);
            serve(1, vecs[i].word, 1'b0);
            chk($sformatf("vec%0d_instr", i), 32'(instr_out), 32'(vecs[i].word));
            issue(0, vecs[i].br, 1'b0);
            chk($sformatf("vec%0d_next", i), 32'(mem_addr), 32'(vecs[i].exp_next));
        end

`ifdef IFETCH_PERF_EN
        do_reset();
        chk("perf_rst_ret", retired_cnt, 32'd0);
        chk("perf_rst_stall", stall_cnt, 32'd0);
        go_start();
        for (int i = 0; i < 3; i++) begin
            serve(2, 16'h0001, 1'b0);
            issue(1, 1'b0, 1'b0);
        end
        chk("perf_ret", retired_cnt, 32'd3);
        chk("perf_stall", stall_cnt, 32'd6);
        do_reset();
        chk("perf_clr_ret", retired_cnt, 32'd0);
        chk("perf_clr_stall", stall_cnt, 32'd0);
`endif

        // Random program against a reference PC model.
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(1) == 1) w[1:0] = 2'b10;
            if (w == 16'hFFFF) w = 16'h0000;
            mem[i] = w;
        end
        do_reset();
        go_start();
        mpc = 0;
        for (int n = 0; n < 40; n++) begin
            chk("rnd_addr", 32'(mem_addr), 32'(mpc));
            serve($urandom_range(1, 3), mem[mem_addr], 1'b1);
            chk("rnd_instr", 32'(instr_out), 32'(mem[mpc]));
            br = 1'($urandom_range(1));
            issue($urandom_range(0, 2), br, 1'b1);
            off = int'(mem[mpc][12:5]);
            if (off > 127) off -= 256;
            if (mem[mpc][1:0] == 2'b10 && br) mpc = (mpc + off + 256) % 256;
            else mpc = (mpc + 1) % 256;
        end
        chk("rnd_final_addr", 32'(mem_addr), 32'(mpc));
        mem[mpc] = 16'hFFFF;
        serve(1, mem[mem_addr], 1'b0);
        chk("rnd_halted", 32'(halted), 32'd1);
        chk("rnd_halt_pc", 32'(pc), 32'(mpc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
